// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit launch FSM states and default data width.
// Also imported by the transmitter instance so both sides agree on DBIT.
package uart_pkg;

    localparam int DBIT_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_fifo_sync.sv
// Synchronous circular byte FIFO with a separate occupancy counter.
// Flush clears pointers and count; stored data is left in place.
module fifo_sync
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            wr_i,
    input  logic [DBIT-1:0] wdata_i,
    input  logic            rd_i,
    output logic [DBIT-1:0] rdata_o,
    output logic [ADDR_W:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;

    assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is the registered value, so a pop never frees room for a same-cycle write.
    assign push = wr_i && !full_o && !flush_i;
    assign pop  = rd_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue and launch controller in front of the UART transmitter:
// one tx_start per byte, tx_din held until the next launch.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    input  logic            flush,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            busy,
    output logic            overflow
);

    tx_state_e       state_q, state_d;
    logic            tx_start_q, tx_start_d;
    logic [DBIT-1:0] tx_din_q, tx_din_d;
    logic            ovf_q, ovf_d;
    logic            pop;
    logic [DBIT-1:0] head;

    fifo_sync #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .wr_i    (wr_en),
        .wdata_i (wr_data),
        .rd_i    (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Flush wins over a launch in the same cycle.
                if (!empty && !flush) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_din_d   = head;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick) state_d = IDLE;
            end
        endcase
    end

    assign ovf_d = wr_en && full && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign busy     = (state_q == WAIT);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer with a queue-based
// reference model, a launch scoreboard and a simple transmitter model.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       full, empty, busy, overflow;
    logic [4:0] count;

    int tests = 0;
    int fails = 0;

    // transmitter model
    int frame_len = 20;
    bit stall = 1'b0;
    int tx_cnt = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    bit         m_start = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_din = 8'h00;
    int         m_sz;
    bit         m_launch;
    bit         mon_en = 1'b0;
    logic [7:0] sb_e;

    uart_tx_buffer #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a byte queue plus an in-flight flag.
    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_start = 1'b0;
            m_ovf   = 1'b0;
            m_din   = 8'h00;
        end else begin
            m_sz     = m_q.size();
            m_launch = !m_busy && (m_sz != 0) && !flush;
            m_start  = m_launch;
            m_ovf    = wr_en && !flush && (m_sz == DEPTH);
            if (m_launch) begin
                m_din  = m_q.pop_front();
                exp_q.push_back(m_din);
                m_busy = 1'b1;
            end else if (m_busy && tx_done_tick) begin
                m_busy = 1'b0;
            end
            if (flush) m_q.delete();
            else if (wr_en && m_sz < DEPTH) m_q.push_back(wr_data);
        end
    end

    // Transmitter: done pulse frame_len cycles after each start.
    always @(negedge clk) begin
        tx_done_tick = 1'b0;
        if (!rst) begin
            tx_cnt = 0;
        end else if (tx_start) begin
            tx_cnt = frame_len;
        end else if (tx_cnt > 0 && !stall) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done_tick = 1'b1;
        end
    end

    // Monitor: per-cycle output check and launch scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_start", int'(tx_start), int'(m_start));
            chk("tx_din", int'(tx_din), int'(m_din));
            chk("count", int'(count), m_q.size());
            chk("full", int'(full), int'(m_q.size() == DEPTH));
            chk("empty", int'(empty), int'(m_q.size() == 0));
            chk("busy", int'(busy), int'(m_busy));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (tx_start || exp_q.size() != 0) begin
                tests++;
                if (!tx_start) begin
                    fails++;
                    sb_e = exp_q.pop_front();
                    $display("FAIL sb_launch: no tx_start, expected byte %h at %0t",
                             sb_e, $time);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_launch: unexpected tx_start byte %h at %0t",
                             tx_din, $time);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (tx_din !== sb_e) begin
                        fails++;
                        $display("FAIL sb_byte: got %h expected %h at %0t",
                                 tx_din, sb_e, $time);
                    end
                end
            end
        end
    end

    task automatic wr(logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((m_busy || m_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        tests++;
        if (m_busy || m_q.size() != 0) begin
            fails++;
            $display("FAIL drain: timeout busy=%0d queued=%0d required 0",
                     m_busy, m_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_din", int'(tx_din), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        rst = 1'b1;
        tick();

        // single byte, long frame
        frame_len = 160;
        wr(8'hA5);
        tick();
        chk("single_start", int'(tx_start), 1);
        chk("single_din", int'(tx_din), 'hA5);
        tick();
        chk("single_pulse_len", int'(tx_start), 0);
        chk("single_busy", int'(busy), 1);
        drain(1000);
        chk("single_idle", int'(busy), 0);

        // burst of three, includes write on the launch cycle
        frame_len = 20;
        wr(8'h48);
        wr(8'h69);
        wr(8'h0D);
        drain(1000);

        // stalled transmitter, overflow on the 18th write
        stall = 1'b1;
        for (int i = 0; i < 18; i++) wr(8'(8'h10 + i));
        chk("full_count", int'(count), 16);
        chk("full_flag", int'(full), 1);
        tick();
        stall = 1'b0;
        drain(5000);

        // flush mid-frame with a same-cycle write
        frame_len = 30;
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        tick();
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("flush_empty", int'(empty), 1);
        chk("flush_busy", int'(busy), 1);
        drain(1000);

        // reset mid-frame with four bytes queued
        frame_len = 40;
        for (int i = 0; i < 5; i++) wr(8'(8'hD0 + i));
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_din", int'(tx_din), 0);
        chk("mrst_count", int'(count), 0);
        wr(8'h31);
        tick();
        chk("mrst_relaunch", int'(tx_din), 'h31);
        drain(1000);

        // randomized traffic
        frame_len = 3;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) frame_len = $urandom_range(1, 8);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 249) != 0);
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        drain(5000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
